gent_policy_checker: RTL and testbench

// - Consumer end of the constraint-randomization flow: checks a stream of randomized items against up to NUM_POLICIES policies.
// - Counts items that pass and items that fail, and captures the first violation.
// - Sits between a hardware stimulus source and the testbench scoreboard; replaces software re-checking of distributions.

---
 rtl/gent_policy_pkg.sv | 23 ++
 rtl/gent_policy_eval.sv | 32 +++
 rtl/gent_policy_checker.sv | 186 ++++++++++++++++++
 tb/tb_gent_policy_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gent_policy_pkg.sv
// Shared types and default sizing for the policy checker slice.
// Ports: none (package only).
// Holds the policy kind encoding, the checker FSM states and default parameter values.
package gent_policy_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_NUM_POLICIES = 4;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    IN_RANGE  = 2'd0,
    OUT_RANGE = 2'd1,
    EQ        = 2'd2,
    NEQ       = 2'd3
  } policy_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } checker_state_e;

endpackage

// File: rtl/gent_policy_eval.sv
// Single policy slot evaluator: flags a violation of one policy by one item.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: en/kind/lo/hi = slot config, d = item value, viol = 1 when the item breaks the policy.
module gent_policy_eval
  import gent_policy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              en,
  input  policy_kind_e      kind,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] d,
  output logic              viol
);

  // All comparisons are unsigned. An inverted IN_RANGE (lo > hi) can never
  // satisfy both bounds, so it fails every item without special casing.
  always_comb begin
    viol = 1'b0;
    if (en) begin
      case (kind)
        IN_RANGE:  viol = !((d >= lo) && (d <= hi));
        OUT_RANGE: viol = !((d < lo) || (d > hi));
        EQ:        viol = (d != lo);
        NEQ:       viol = (d == lo);
        default:   viol = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/gent_policy_checker.sv
// Checks a stream of items against NUM_POLICIES policies, counts pass/fail, captures the first violation.
// Latency: 2 cycles from item handshake to visible counters/capture; throughput 1 item/cycle.
// Backpressure: item_ready is high only in RUN; stop closes the input, drains the stage, then pulses done.
// Ports: start/stop control; pol_en/pol_kind/pol_lo/pol_hi config (latched on start);
//        item_valid/item_ready/item_data stream; busy/done status; pass_cnt/fail_cnt/first_fail_* results.
// Optional: define GENT_POLICY_CHECKER_HIST_EN to add pol_fail_cnt, per-slot saturating violation counts.
module gent_policy_checker
  import gent_policy_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_POLICIES = DEF_NUM_POLICIES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic [NUM_POLICIES-1:0]        pol_en,
  input  logic [2*NUM_POLICIES-1:0]      pol_kind,
  input  logic [DATA_W*NUM_POLICIES-1:0] pol_lo,
  input  logic [DATA_W*NUM_POLICIES-1:0] pol_hi,
  input  logic                           item_valid,
  output logic                           item_ready,
  input  logic [DATA_W-1:0]              item_data,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               pass_cnt,
  output logic [CNT_W-1:0]               fail_cnt,
  output logic                           first_fail_vld,
  output logic [DATA_W-1:0]              first_fail_data,
  output logic [NUM_POLICIES-1:0]        first_fail_mask
`ifdef GENT_POLICY_CHECKER_HIST_EN
  ,
  output logic [CNT_W*NUM_POLICIES-1:0]  pol_fail_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  checker_state_e state, state_nxt;

  logic                           start_acc;
  logic                           handshake;
  logic [NUM_POLICIES-1:0]        viol;

  logic [NUM_POLICIES-1:0]        en_q;
  logic [2*NUM_POLICIES-1:0]      kind_q;
  logic [DATA_W*NUM_POLICIES-1:0] lo_q;
  logic [DATA_W*NUM_POLICIES-1:0] hi_q;

  logic                           pipe_vld;
  logic [DATA_W-1:0]              pipe_dat;
  logic [NUM_POLICIES-1:0]        pipe_mask;

  // start only takes effect from IDLE; in RUN/DRAIN it is ignored.
  assign start_acc = (state == IDLE) && start;
  assign handshake = item_valid && item_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (stop)      state_nxt = DRAIN;
      DRAIN:   if (!pipe_vld) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The stage drains one cycle after the last handshake, so done is raised
  // in the DRAIN cycle whose stage is empty: the counters are final by then.
  always_comb begin
    item_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      RUN: begin
        item_ready = 1'b1;
        busy       = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
        done = !pipe_vld;
      end
      default: ;
    endcase
  end

  // ---------------- Config shadow registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      kind_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else if (start_acc) begin
      en_q   <= pol_en;
      kind_q <= pol_kind;
      lo_q   <= pol_lo;
      hi_q   <= pol_hi;
    end
  end

  // ---------------- Policy evaluation ----------------
  for (genvar g = 0; g < NUM_POLICIES; g++) begin : g_eval
    gent_policy_eval #(
      .DATA_W (DATA_W)
    ) u_eval (
      .en   (en_q[g]),
      .kind (policy_kind_e'(kind_q[2*g +: 2])),
      .lo   (lo_q[DATA_W*g +: DATA_W]),
      .hi   (hi_q[DATA_W*g +: DATA_W]),
      .d    (item_data),
      .viol (viol[g])
    );
  end

  // ---------------- Pipeline stage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= 1'b0;
      pipe_dat  <= '0;
      pipe_mask <= '0;
    end else begin
      pipe_vld <= handshake;
      if (handshake) begin
        pipe_dat  <= item_data;
        pipe_mask <= viol;
      end
    end
  end

  // ---------------- Counters and first-failure capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_vld  <= 1'b0;
      first_fail_data <= '0;
      first_fail_mask <= '0;
    end else if (start_acc) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_vld  <= 1'b0;
      first_fail_data <= '0;
      first_fail_mask <= '0;
    end else if (pipe_vld) begin
      if (pipe_mask == '0) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
        if (!first_fail_vld) begin
          first_fail_vld  <= 1'b1;
          first_fail_data <= pipe_dat;
          first_fail_mask <= pipe_mask;
        end
      end
    end
  end

`ifdef GENT_POLICY_CHECKER_HIST_EN
  // ---------------- Per-slot violation histogram ----------------
  for (genvar g = 0; g < NUM_POLICIES; g++) begin : g_hist
    logic [CNT_W-1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                               hist_q <= '0;
      else if (start_acc)                                    hist_q <= '0;
      else if (pipe_vld && pipe_mask[g] && hist_q != CNT_MAX) hist_q <= hist_q + CNT_ONE;
    end

    assign pol_fail_cnt[CNT_W*g +: CNT_W] = hist_q;
  end
`else
  // Histogram disabled: no per-slot counters are built.
`endif

endmodule

// File: tb/tb_gent_policy_checker.sv
// Directed self-checking bench for gent_policy_checker.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_gent_policy_checker;
  import gent_policy_pkg::*;

  localparam int DW = 32;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stop;
  logic [NP-1:0]   pol_en;
  logic [2*NP-1:0] pol_kind;
  logic [DW*NP-1:0] pol_lo;
  logic [DW*NP-1:0] pol_hi;
  logic            item_valid;
  logic [DW-1:0]   item_data;

  logic            item_ready, busy, done, first_fail_vld;
  logic [15:0]     pass_cnt, fail_cnt;
  logic [DW-1:0]   first_fail_data;
  logic [NP-1:0]   first_fail_mask;

  logic            b_item_ready, b_busy, b_done, b_first_fail_vld;
  logic [3:0]      b_pass_cnt, b_fail_cnt;
  logic [DW-1:0]   b_first_fail_data;
  logic [NP-1:0]   b_first_fail_mask;

`ifdef GENT_POLICY_CHECKER_HIST_EN
  logic [16*NP-1:0] pol_fail_cnt;
  logic [4*NP-1:0]  b_pol_fail_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gent_policy_checker #(.DATA_W(DW), .NUM_POLICIES(NP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pol_en(pol_en), .pol_kind(pol_kind), .pol_lo(pol_lo), .pol_hi(pol_hi),
    .item_valid(item_valid), .item_ready(item_ready), .item_data(item_data),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_data(first_fail_data),
    .first_fail_mask(first_fail_mask)
`ifdef GENT_POLICY_CHECKER_HIST_EN
    , .pol_fail_cnt(pol_fail_cnt)
`endif
  );

  gent_policy_checker #(.DATA_W(DW), .NUM_POLICIES(NP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pol_en(pol_en), .pol_kind(pol_kind), .pol_lo(pol_lo), .pol_hi(pol_hi),
    .item_valid(item_valid), .item_ready(b_item_ready), .item_data(item_data),
    .busy(b_busy), .done(b_done), .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt),
    .first_fail_vld(b_first_fail_vld), .first_fail_data(b_first_fail_data),
    .first_fail_mask(b_first_fail_mask)
`ifdef GENT_POLICY_CHECKER_HIST_EN
    , .pol_fail_cnt(b_pol_fail_cnt)
`endif
  );

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    pol_en   = '0;
    pol_kind = '0;
    pol_lo   = '0;
    pol_hi   = '0;
  endtask

  task automatic set_slot(input int idx, input policy_kind_e kind,
                          input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    pol_en[idx]             = 1'b1;
    pol_kind[2*idx +: 2]    = kind;
    pol_lo[DW*idx +: DW]    = lo;
    pol_hi[DW*idx +: DW]    = hi;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    item_valid = 1'b1;
    item_data  = d;
    tick();
    item_valid = 1'b0;
  endtask

  // Pulse stop, then watch a bounded window and count done pulses.
  task automatic stop_and_drain(output int pulses);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pulses = 0;
    repeat (8) begin
      if (done) pulses++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (item_ready !== 1'b0) begin failures++; $display("FAIL reset_item_ready got=%0b want=0", item_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (pass_cnt !== 16'd0) begin failures++; $display("FAIL reset_pass_cnt got=%0d want=0", pass_cnt); end
    checks++; if (fail_cnt !== 16'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d want=0", fail_cnt); end
    checks++; if (first_fail_vld !== 1'b0) begin failures++; $display("FAIL reset_ff_vld got=%0b want=0", first_fail_vld); end
    checks++; if (first_fail_data !== 32'd0) begin failures++; $display("FAIL reset_ff_data got=%0d want=0", first_fail_data); end
    checks++; if (first_fail_mask !== 4'd0) begin failures++; $display("FAIL reset_ff_mask got=%b want=0000", first_fail_mask); end
    rst = 1'b0;
    stop = 1'b1;  // stop alone in IDLE must be ignored
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_stop_ignored busy got=%0b want=0", busy); end
  endtask

  task automatic test_in_range();
    int pulses;
    clear_cfg();
    set_slot(0, IN_RANGE, 32'd10, 32'd20);
    start = 1'b1;
    stop  = 1'b1;  // start wins over stop in IDLE
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (item_ready !== 1'b1) begin failures++; $display("FAIL run_item_ready got=%0b want=1", item_ready); end
    item_valid = 1'b1;
    item_data = 32'd10; tick();
    item_data = 32'd20; tick();
    item_data = 32'd21; tick();
    item_valid = 1'b0;
    stop_and_drain(pulses);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL range_done_pulses got=%0d want=1", pulses); end
    checks++; if (pass_cnt !== 16'd2) begin failures++; $display("FAIL range_pass_cnt got=%0d want=2", pass_cnt); end
    checks++; if (fail_cnt !== 16'd1) begin failures++; $display("FAIL range_fail_cnt got=%0d want=1", fail_cnt); end
    checks++; if (first_fail_vld !== 1'b1) begin failures++; $display("FAIL range_ff_vld got=%0b want=1", first_fail_vld); end
    checks++; if (first_fail_data !== 32'd21) begin failures++; $display("FAIL range_ff_data got=%0d want=21", first_fail_data); end
    checks++; if (first_fail_mask !== 4'b0001) begin failures++; $display("FAIL range_ff_mask got=%b want=0001", first_fail_mask); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL range_busy_after got=%0b want=0", busy); end
  endtask

  task automatic test_eq_neq();
    int pulses;
    clear_cfg();
    set_slot(0, EQ,  32'd5, 32'd0);
    set_slot(1, NEQ, 32'd5, 32'd0);
    do_start();
    send(32'd5);
    tick();
    checks++; if (fail_cnt !== 16'd1) begin failures++; $display("FAIL eq_fail_cnt1 got=%0d want=1", fail_cnt); end
    checks++; if (first_fail_mask !== 4'b0010) begin failures++; $display("FAIL eq_ff_mask got=%b want=0010", first_fail_mask); end
    send(32'd6);
    tick();
    checks++; if (fail_cnt !== 16'd2) begin failures++; $display("FAIL eq_fail_cnt2 got=%0d want=2", fail_cnt); end
    checks++; if (pass_cnt !== 16'd0) begin failures++; $display("FAIL eq_pass_cnt got=%0d want=0", pass_cnt); end
    checks++; if (first_fail_data !== 32'd5) begin failures++; $display("FAIL eq_ff_data_kept got=%0d want=5", first_fail_data); end
    checks++; if (first_fail_mask !== 4'b0010) begin failures++; $display("FAIL eq_ff_mask_kept got=%b want=0010", first_fail_mask); end
    stop_and_drain(pulses);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL eq_done_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_out_range_empty();
    int pulses;
    clear_cfg();
    set_slot(2, OUT_RANGE, 32'd10, 32'd20);
    set_slot(3, IN_RANGE,  32'd50, 32'd40);  // empty range: always violated
    do_start();
    item_valid = 1'b1;
    item_data = 32'd9;  tick();  // slot3 only   -> 1000
    item_data = 32'd15; tick();  // slots 2 and 3 -> 1100
    item_valid = 1'b0;
    tick();
    checks++; if (fail_cnt !== 16'd2) begin failures++; $display("FAIL out_fail_cnt got=%0d want=2", fail_cnt); end
    checks++; if (first_fail_mask !== 4'b1000) begin failures++; $display("FAIL out_ff_mask got=%b want=1000", first_fail_mask); end
    stop_and_drain(pulses);
  endtask

  task automatic test_saturate();
    int pulses;
    clear_cfg();
    do_start();
    item_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      item_data = DW'(i * 3);
      tick();
    end
    item_valid = 1'b0;
    tick();
    checks++; if (b_pass_cnt !== 4'd15) begin failures++; $display("FAIL sat_pass_cnt got=%0d want=15", b_pass_cnt); end
    checks++; if (b_fail_cnt !== 4'd0) begin failures++; $display("FAIL sat_fail_cnt got=%0d want=0", b_fail_cnt); end
    checks++; if (pass_cnt !== 16'd20) begin failures++; $display("FAIL wide_pass_cnt got=%0d want=20", pass_cnt); end
    stop_and_drain(pulses);
  endtask

  task automatic test_back_to_back_stop();
    clear_cfg();
    set_slot(0, IN_RANGE, 32'd0, 32'd100);
    do_start();
    item_valid = 1'b1;
    item_data = 32'd1; tick();
    item_data = 32'd2; tick();
    item_data = 32'd3;
    stop = 1'b1;
    tick();
    item_valid = 1'b0;
    stop = 1'b0;
    checks++; if (item_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop got=%0b want=0", item_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_early got=%0b want=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_pulse got=%0b want=1", done); end
    checks++; if (pass_cnt !== 16'd3) begin failures++; $display("FAIL b2b_pass_cnt got=%0d want=3", pass_cnt); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%0b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%0b want=0", busy); end
  endtask

  task automatic test_latched_config();
    int pulses;
    clear_cfg();
    set_slot(0, IN_RANGE, 32'd10, 32'd20);
    do_start();
    pol_lo[31:0] = 32'd0;
    send(32'd5);
    tick();
    checks++; if (fail_cnt !== 16'd1) begin failures++; $display("FAIL latch_fail_cnt got=%0d want=1", fail_cnt); end
    checks++; if (pass_cnt !== 16'd0) begin failures++; $display("FAIL latch_pass_cnt got=%0d want=0", pass_cnt); end
    checks++; if (first_fail_data !== 32'd5) begin failures++; $display("FAIL latch_ff_data got=%0d want=5", first_fail_data); end
    stop_and_drain(pulses);
  endtask

  task automatic test_reset_midrun();
    int pulses;
    int seen;
    clear_cfg();
    set_slot(0, EQ, 32'd7, 32'd0);
    do_start();
    send(32'd8);
    tick();
    send(32'd9);  // in flight in the stage when reset hits
    #2;
    rst = 1'b1;
    #1;
    checks++; if (item_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_fsm got=%0b%0b want=00", item_ready, busy); end
    checks++; if (fail_cnt !== 16'd0 || first_fail_vld !== 1'b0) begin failures++; $display("FAIL midrst_results got=%0d/%0b want=0/0", fail_cnt, first_fail_vld); end
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      if (done) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
    do_start();
    send(32'd7);
    stop_and_drain(pulses);
    checks++; if (pass_cnt !== 16'd1) begin failures++; $display("FAIL restart_pass_cnt got=%0d want=1", pass_cnt); end
    checks++; if (fail_cnt !== 16'd0) begin failures++; $display("FAIL restart_fail_cnt got=%0d want=0", fail_cnt); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL restart_done_pulses got=%0d want=1", pulses); end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    item_valid = 1'b0;
    item_data  = '0;
    clear_cfg();
    test_reset();
    test_in_range();
    test_eq_neq();
    test_out_range_empty();
    test_saturate();
    test_back_to_back_stop();
    test_latched_config();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
